seq_detector_prog: RTL and testbench

- Programmable serial bit-pattern detector. It is the parametrised successor of the fixed 010/1001 Mealy detector.
- Pattern, length (1..MAX_LEN) and overlap/non-overlap mode are loaded at runtime.
- Output is Mealy: `y` asserts in the same cycle as the completing bit. The block also keeps a saturating match counter.
- Sits on a 1-bit serial input stream and feeds control/status logic.

---
 rtl/seq_detector_prog_if.sv | 25 ++
 rtl/seq_detector_prog.sv | 84 ++++++++
 tb/tb_seq_detector_prog.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seq_detector_prog_if.sv
// seq_detector_prog_if: configuration, serial stream and status signals of the programmable detector
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               en;
    logic               x;
    logic               y;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    logic               armed;
    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, en, x,
        input  y, match_count, cfg_err, armed
    );
    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, en, x,
        output y, match_count, cfg_err, armed
    );
endinterface

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable Mealy bit-pattern detector with saturating match counter
module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input logic               clk,
    input logic               reset,
    seq_detector_prog_if.slave bus
);
    typedef enum logic {UNCFG, RUN} state_t;
    state_t             state_q, state_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d;
    logic [MAX_LEN-1:0] pat_q, pat_d, mask, win;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovl_q, ovl_d, err_q, err_d;
    logic               cfg_ok, y;
    assign cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    assign win    = {hist_q, bus.x};
    // Only the low len bits of the window and pattern take part in the compare
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) mask[i] = LEN_W'(i) < len_q;
    end
    assign y = (state_q == RUN) && bus.en && !bus.cfg_load
             && (fill_q >= len_q - LEN_W'(1)) && ((win & mask) == (pat_q & mask));
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        len_d   = len_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (bus.cfg_load) begin
            if (cfg_ok) begin
                state_d = RUN;
                pat_d   = bus.cfg_pattern;
                len_d   = bus.cfg_len;
                ovl_d   = bus.cfg_overlap;
                hist_d  = '0;
                fill_d  = '0;
                cnt_d   = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (state_q == RUN && bus.en) begin
            hist_d = (MAX_LEN-1)'(win);
            fill_d = (fill_q == LEN_W'(MAX_LEN-1)) ? fill_q : fill_q + LEN_W'(1);
            if (y && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end
            if (y && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNCFG;
            hist_q  <= '0;
            fill_q  <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    assign bus.y           = y;
    assign bus.match_count = cnt_q;
    assign bus.cfg_err     = err_q;
    assign bus.armed       = (state_q == RUN);
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed-vector bench for the programmable sequence detector
module tb_seq_detector_prog;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    seq_detector_prog_if m_if ();
    seq_detector_prog_if #(.CNT_W(2)) s_if ();
    seq_detector_prog u_dut (.clk(clk), .reset(reset), .bus(m_if));
    seq_detector_prog #(.CNT_W(2)) u_sat (.clk(clk), .reset(reset), .bus(s_if));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o, input logic e, input logic xv);
        m_if.cfg_load    = 1'b1;
        m_if.cfg_pattern = p;
        m_if.cfg_len     = l;
        m_if.cfg_overlap = o;
        m_if.en          = e;
        m_if.x           = xv;
        #4;
        check("load_y", m_if.y, 0);
        tick();
        m_if.cfg_load = 1'b0;
        m_if.en       = 1'b0;
    endtask
    task automatic bit_in(input string tag, input logic b, input logic ey);
        m_if.en = 1'b1;
        m_if.x  = b;
        #4;
        check(tag, m_if.y, ey);
        tick();
        m_if.en = 1'b0;
    endtask
    task automatic stream(input string tag, input logic [7:0] bits, input int n, input logic [7:0] ys, input logic bub);
        for (int i = n - 1; i >= 0; i--) begin
            bit_in(tag, bits[i], ys[i]);
            if (bub) begin
                m_if.x = ~bits[i];
                #4;
                check({tag, "_bubble"}, m_if.y, 0);
                tick();
            end
        end
    endtask
    initial begin
        reset = 1'b1;
        {m_if.cfg_load, m_if.cfg_pattern, m_if.cfg_len, m_if.cfg_overlap, m_if.en, m_if.x} = '0;
        {s_if.cfg_load, s_if.cfg_pattern, s_if.cfg_len, s_if.cfg_overlap, s_if.en, s_if.x} = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_armed", m_if.armed, 0);
        check("rst_count", m_if.match_count, 0);
        check("rst_err", m_if.cfg_err, 0);
        bit_in("uncfg_y", 1'b1, 1'b0);
        // overlapping 010
        load(8'b010, 4'd3, 1'b1, 1'b0, 1'b0);
        check("armed", m_if.armed, 1);
        stream("ovl010", 8'b01010, 5, 8'b00101, 1'b0);
        check("ovl010_cnt", m_if.match_count, 2);
        // non-overlapping 010
        load(8'b010, 4'd3, 1'b0, 1'b0, 1'b0);
        check("load_clr_cnt", m_if.match_count, 0);
        stream("non010", 8'b01010, 5, 8'b00100, 1'b0);
        check("non010_cnt", m_if.match_count, 1);
        // 1001 without and with en=0 bubbles
        load(8'b1001, 4'd4, 1'b1, 1'b0, 1'b0);
        stream("p1001", 8'b1001001, 7, 8'b0001001, 1'b0);
        check("p1001_cnt", m_if.match_count, 2);
        load(8'b1001, 4'd4, 1'b1, 1'b0, 1'b0);
        stream("p1001b", 8'b1001001, 7, 8'b0001001, 1'b1);
        check("p1001b_cnt", m_if.match_count, 2);
        // rejected loads keep the old configuration and history
        load(8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        check("len0_err", m_if.cfg_err, 1);
        check("len0_armed", m_if.armed, 1);
        check("len0_cnt", m_if.match_count, 2);
        tick();
        check("err_pulse", m_if.cfg_err, 0);
        stream("old1001", 8'b1001, 4, 8'b0001, 1'b0);
        check("old1001_cnt", m_if.match_count, 3);
        load(8'hFF, 4'd9, 1'b1, 1'b0, 1'b0);
        check("len9_err", m_if.cfg_err, 1);
        check("len9_cnt", m_if.match_count, 3);
        // fill gate: zeroed history must not count as received bits
        load(8'b010, 4'd3, 1'b1, 1'b0, 1'b0);
        stream("fill", 8'b10, 2, 8'b00, 1'b0);
        // cfg_load with en=1 discards that x
        load(8'b010, 4'd3, 1'b1, 1'b0, 1'b0);
        stream("pre", 8'b01, 2, 8'b00, 1'b0);
        load(8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        check("held_err", m_if.cfg_err, 1);
        bit_in("held_x", 1'b0, 1'b1);
        check("held_cnt", m_if.match_count, 1);
        // saturation on a 2-bit counter
        s_if.cfg_load    = 1'b1;
        s_if.cfg_pattern = 8'b1;
        s_if.cfg_len     = 4'd1;
        s_if.cfg_overlap = 1'b1;
        tick();
        s_if.cfg_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_if.en = 1'b1;
            s_if.x  = 1'b1;
            #4;
            check("sat_y", s_if.y, 1);
            tick();
            check("sat_cnt", s_if.match_count, (i < 3) ? i + 1 : 3);
        end
        s_if.en = 1'b0;
        // reset mid-stream
        load(8'b010, 4'd3, 1'b1, 1'b0, 1'b0);
        stream("pre_rst", 8'b0101, 4, 8'b0010, 1'b0);
        check("pre_rst_cnt", m_if.match_count, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_armed", m_if.armed, 0);
        check("mid_rst_cnt", m_if.match_count, 0);
        stream("post_rst", 8'b01010, 5, 8'b00000, 1'b0);
        check("post_rst_armed", m_if.armed, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
